ioctl_dl_master: RTL

- Drives the ioctl download interface (ioctl_download/wr/addr/dout/index, honouring ioctl_wait) toward the emu core. It is the transmitter side of the HPS-style download the core receives.
- Pulls bytes from a valid/ready byte source (ROM image file reader, BRAM, testbench queue) and emits one write strobe per byte with incrementing address.
- Sits beside emu in sim and in self-loading builds, replacing the HPS as loader of ROM index 0..n.

---
 rtl/ioctl_dl_pkg.sv | 27 ++
 rtl/ioctl_dl_timer.sv | 35 +++
 rtl/ioctl_dl_master.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/ioctl_dl_pkg.sv
// ============================================================================
// Module      : ioctl_dl_pkg
// Description : Shared state encoding and default timing constants for the
//               ioctl download master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ioctl_dl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_FETCH = 3'd2,
        ST_WRITE = 3'd3,
        ST_GAP   = 3'd4,
        ST_TAIL  = 3'd5
    } dl_state_t;

    localparam int DL_SETUP_CYCLES = 4;
    localparam int DL_WR_GAP       = 2;
    localparam int DL_TAIL_CYCLES  = 4;
    localparam int DL_TIMER_W      = 8;

endpackage

`default_nettype wire

// File: rtl/ioctl_dl_timer.sv
// ============================================================================
// Module      : ioctl_dl_timer
// Description : Reloadable down-counter that saturates at zero; used for the
//               SETUP, GAP and TAIL waits of the download master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ioctl_dl_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_value,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/ioctl_dl_master.sv
// ============================================================================
// Module      : ioctl_dl_master
// Description : Drives the ioctl download interface from a valid/ready byte
//               source. Define IOCTL_DL_CHECKSUM_EN to add a 16-bit checksum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ioctl_dl_master
    import ioctl_dl_pkg::*;
#(
    parameter int ADDR_W       = 25,
    parameter int SETUP_CYCLES = DL_SETUP_CYCLES,
    parameter int WR_GAP       = DL_WR_GAP,
    parameter int TAIL_CYCLES  = DL_TAIL_CYCLES
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        index,
    input  logic [ADDR_W-1:0] length,
    input  logic              abort,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ioctl_download,
    output logic              ioctl_wr,
    output logic [ADDR_W-1:0] ioctl_addr,
    output logic [7:0]        ioctl_dout,
    output logic [7:0]        ioctl_index,
    input  logic              ioctl_wait,
    output logic              busy,
    output logic              done
`ifdef IOCTL_DL_CHECKSUM_EN
    ,
    output logic [15:0]       checksum
`endif
);

    localparam logic [DL_TIMER_W-1:0] C_SETUP_LOAD = DL_TIMER_W'(SETUP_CYCLES - 1);
    localparam logic [DL_TIMER_W-1:0] C_GAP_LOAD   = DL_TIMER_W'(WR_GAP);
    localparam logic [DL_TIMER_W-1:0] C_TAIL_LOAD  = DL_TIMER_W'(TAIL_CYCLES - 1);

    dl_state_t         r_state, w_state_nxt;
    logic              r_download, w_download_nxt;
    logic              r_wr, w_wr_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic              r_s_ready, w_s_ready_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [7:0]        r_dout, w_dout_nxt;
    logic [7:0]        r_index, w_index_nxt;
    logic [ADDR_W-1:0] r_remaining, w_remaining_nxt;
    logic [ADDR_W-1:0] w_rem_left;
    logic              w_tmr_load;
    logic [DL_TIMER_W-1:0] w_tmr_val;
    logic              w_tmr_zero;

    ioctl_dl_timer #(
        .WIDTH   (DL_TIMER_W)
    ) u_timer (
        .clk     (clk_sys),
        .rst     (reset),
        .i_load  (w_tmr_load),
        .i_value (w_tmr_val),
        .o_zero  (w_tmr_zero)
    );

    // r_wr is only ever high during the strobe cycle in GAP
    assign w_rem_left = r_wr ? (r_remaining - 1'b1) : r_remaining;

    always_comb begin
        w_state_nxt     = r_state;
        w_download_nxt  = r_download;
        w_wr_nxt        = 1'b0;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        w_s_ready_nxt   = 1'b0;
        w_addr_nxt      = r_addr;
        w_dout_nxt      = r_dout;
        w_index_nxt     = r_index;
        w_remaining_nxt = r_remaining;
        w_tmr_load      = 1'b0;
        w_tmr_val       = '0;

        case (r_state)
            ST_IDLE: begin
                if (start && !abort) begin
                    if (length != '0) begin
                        w_state_nxt     = ST_SETUP;
                        w_download_nxt  = 1'b1;
                        w_busy_nxt      = 1'b1;
                        w_addr_nxt      = '0;
                        w_index_nxt     = index;
                        w_remaining_nxt = length;
                        w_tmr_load      = 1'b1;
                        w_tmr_val       = C_SETUP_LOAD;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                if (w_tmr_zero) begin
                    w_state_nxt   = ST_FETCH;
                    w_s_ready_nxt = 1'b1;
                end
            end
            ST_FETCH: begin
                if (s_valid && r_s_ready) begin
                    w_dout_nxt  = s_data;
                    w_state_nxt = ST_WRITE;
                end else begin
                    w_s_ready_nxt = 1'b1;
                end
            end
            ST_WRITE: begin
                if (!ioctl_wait) begin
                    w_wr_nxt    = 1'b1;
                    w_state_nxt = ST_GAP;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = C_GAP_LOAD;
                end
            end
            ST_GAP: begin
                if (r_wr) begin
                    w_remaining_nxt = w_rem_left;
                    // Skip the increment after the last byte so the address never wraps
                    if (w_rem_left != '0) begin
                        w_addr_nxt = r_addr + 1'b1;
                    end
                end
                if (w_tmr_zero) begin
                    if (w_rem_left == '0) begin
                        w_state_nxt = ST_TAIL;
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = C_TAIL_LOAD;
                    end else begin
                        w_state_nxt   = ST_FETCH;
                        w_s_ready_nxt = 1'b1;
                    end
                end
            end
            ST_TAIL: begin
                if (w_tmr_zero) begin
                    w_state_nxt    = ST_IDLE;
                    w_download_nxt = 1'b0;
                    w_busy_nxt     = 1'b0;
                    w_done_nxt     = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (abort && (r_state != ST_IDLE)) begin
            w_state_nxt    = ST_IDLE;
            w_download_nxt = 1'b0;
            w_wr_nxt       = 1'b0;
            w_busy_nxt     = 1'b0;
            w_s_ready_nxt  = 1'b0;
            w_done_nxt     = 1'b0;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_download  <= 1'b0;
            r_wr        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_s_ready   <= 1'b0;
            r_addr      <= '0;
            r_dout      <= '0;
            r_index     <= '0;
            r_remaining <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_download  <= w_download_nxt;
            r_wr        <= w_wr_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_s_ready   <= w_s_ready_nxt;
            r_addr      <= w_addr_nxt;
            r_dout      <= w_dout_nxt;
            r_index     <= w_index_nxt;
            r_remaining <= w_remaining_nxt;
        end
    end

    assign s_ready        = r_s_ready;
    assign ioctl_download = r_download;
    assign ioctl_wr       = r_wr;
    assign ioctl_addr     = r_addr;
    assign ioctl_dout     = r_dout;
    assign ioctl_index    = r_index;
    assign busy           = r_busy;
    assign done           = r_done;

`ifdef IOCTL_DL_CHECKSUM_EN
    logic [15:0] r_checksum;
    logic        w_cks_clr;
    logic        w_cks_add;

    assign w_cks_clr = (r_state == ST_IDLE) && start && !abort;
    assign w_cks_add = (r_state == ST_GAP) && r_wr;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_checksum <= '0;
        end else if (w_cks_clr) begin
            r_checksum <= '0;
        end else if (w_cks_add) begin
            r_checksum <= r_checksum + {8'h00, r_dout};
        end
    end

    assign checksum = r_checksum;
`endif

endmodule

`default_nettype wire
